// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: memory FSM states,
// the bundle of stall/flush controls and the hard-wired zero register index.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_exe;
        logic stall_mem;
        logic flush_id;
        logic flush_exe;
        logic flush_wb;
    } pipe_ctl_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Purely combinational load-use and EXE redirect detection.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_id_i,
    input  logic [4:0] rs2_id_i,
    input  logic [4:0] rd_exe_i,
    input  logic       mem_read_exe_i,
    input  logic       branch_taken_exe_i,
    input  logic       jump_exe_i,
    output logic       loaduse_o,
    output logic       redirect_o
);

    // x0 is never a real producer, so a load targeting it cannot cause a hazard.
    assign loaduse_o  = mem_read_exe_i && (rd_exe_i != REG_X0) &&
                        ((rd_exe_i == rs1_id_i) || (rd_exe_i == rs2_id_i));
    assign redirect_o = branch_taken_exe_i | jump_exe_i;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler with a data-memory request/ack FSM and timeout.
// Optional perf counters are enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic [4:0]  rd_exe,
    input  logic        MemRead_exe,
    input  logic        branch_taken_exe,
    input  logic        jump_exe,
    input  logic        mem_req_mem,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic [31:0] load_data,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_exe,
    output logic        stall_mem,
    output logic        flush_id,
    output logic        flush_exe,
    output logic        flush_wb,
    output logic        mem_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_mem_stall,
    output logic [CNT_W-1:0] cnt_loaduse,
    output logic [CNT_W-1:0] cnt_redirect
`endif
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    mem_state_t    state_q;
    logic          dmem_req_q;
    logic          served_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [31:0]   load_data_q;
    logic          mem_err_q;

    logic          mem_busy;
    logic          loaduse;
    logic          redirect;
    pipe_ctl_t     ctl;

    hazard_detect u_hazard_detect (
        .rs1_id_i           (rs1_id),
        .rs2_id_i           (rs2_id),
        .rd_exe_i           (rd_exe),
        .mem_read_exe_i     (MemRead_exe),
        .branch_taken_exe_i (branch_taken_exe),
        .jump_exe_i         (jump_exe),
        .loaduse_o          (loaduse),
        .redirect_o         (redirect)
    );

    // served masks the still-asserted mem_req_mem during the release cycle.
    assign mem_busy = ((state_q == RUN) && mem_req_mem && !served_q) ||
                      (state_q == MEM_WAIT);

    always_comb begin
        ctl = '0;
        if (rst) begin
            ctl = '0;
        end else if (mem_busy) begin
            ctl.stall_if  = 1'b1;
            ctl.stall_id  = 1'b1;
            ctl.stall_exe = 1'b1;
            ctl.stall_mem = 1'b1;
            ctl.flush_wb  = 1'b1;
        end else if (redirect) begin
            ctl.flush_id  = 1'b1;
            ctl.flush_exe = 1'b1;
        end else if (loaduse) begin
            ctl.stall_if  = 1'b1;
            ctl.stall_id  = 1'b1;
            ctl.flush_exe = 1'b1;
        end
    end

    assign stall_if  = ctl.stall_if;
    assign stall_id  = ctl.stall_id;
    assign stall_exe = ctl.stall_exe;
    assign stall_mem = ctl.stall_mem;
    assign flush_id  = ctl.flush_id;
    assign flush_exe = ctl.flush_exe;
    assign flush_wb  = ctl.flush_wb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            dmem_req_q  <= 1'b0;
            served_q    <= 1'b0;
            tmo_cnt_q   <= '0;
            load_data_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    served_q <= 1'b0;
                    if (mem_busy) begin
                        state_q    <= MEM_WAIT;
                        dmem_req_q <= 1'b1;
                        tmo_cnt_q  <= '0;
                    end
                end
                MEM_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    // A late ack on the final cycle still counts as success.
                    if (dmem_ack) begin
                        load_data_q <= dmem_rdata;
                        dmem_req_q  <= 1'b0;
                        served_q    <= 1'b1;
                        state_q     <= RUN;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        mem_err_q   <= 1'b1;
                        load_data_q <= '0;
                        dmem_req_q  <= 1'b0;
                        served_q    <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    dmem_req_q <= 1'b0;
                    served_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_req  = dmem_req_q;
    assign load_data = load_data_q;
    assign mem_err   = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_mem_stall_q;
    logic [CNT_W-1:0] cnt_loaduse_q;
    logic [CNT_W-1:0] cnt_redirect_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Each counter only advances when its condition actually wins priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_mem_stall_q <= '0;
            cnt_loaduse_q   <= '0;
            cnt_redirect_q  <= '0;
        end else if (mem_busy) begin
            cnt_mem_stall_q <= sat_inc(cnt_mem_stall_q);
        end else if (redirect) begin
            cnt_redirect_q  <= sat_inc(cnt_redirect_q);
        end else if (loaduse) begin
            cnt_loaduse_q   <= sat_inc(cnt_loaduse_q);
        end
    end

    assign cnt_mem_stall = cnt_mem_stall_q;
    assign cnt_loaduse   = cnt_loaduse_q;
    assign cnt_redirect  = cnt_redirect_q;
`endif

endmodule
